// File: rtl/result_packet_writer.sv
// Result packet writer: streams matched packet words into the current result SRAM slot and
// pulses inc_addr when the slot is consumed. Define RESULT_WRITER_LEN_HDR_EN for a length header.
module result_packet_writer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SLOT_BYTES = 1550
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slot_base,
  input  logic              slot_wen,
  input  logic [DATA_W-1:0] pkt_data,
  input  logic              pkt_valid,
  input  logic              pkt_end,
  output logic              pkt_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wen,
  input  logic              sram_ack,
  output logic              inc_addr,
  output logic              overflow
);

`ifdef RESULT_WRITER_LEN_HDR_EN
  localparam int unsigned DataStart = 4;
`else
  localparam int unsigned DataStart = 0;
`endif
  localparam int unsigned Capacity = (SLOT_BYTES - DataStart) / 4;
  localparam int unsigned CntW     = $clog2(Capacity + 1);

  localparam logic [ADDR_W-1:0] DataStartW = ADDR_W'(DataStart);
  localparam logic [CntW-1:0]   CapW       = CntW'(Capacity);

  typedef enum logic [2:0] {StIdle, StWrite, StAccept, StDrop, StHdr, StDone} state_e;

  state_e            state_q;
  logic              armed_q;
  logic              end_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] offset_q;
  logic [CntW-1:0]   wcount_q;
  logic              accept;

`ifdef RESULT_WRITER_LEN_HDR_EN
  // Header word: stored byte count in [15:0], overflow flag in the top bit.
  function automatic logic [DATA_W-1:0] hdr_word(input logic ovf, input logic [CntW-1:0] words);
    logic [DATA_W-1:0] w;
    w           = '0;
    w[15:0]     = 16'(words) << 2;
    w[DATA_W-1] = ovf;
    return w;
  endfunction
`endif

  always_comb begin
    pkt_ready = 1'b0;
    case (state_q)
      StIdle:           pkt_ready = armed_q;
      StAccept, StDrop: pkt_ready = 1'b1;
      default:          pkt_ready = 1'b0;
    endcase
  end

  assign accept = pkt_valid && pkt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      armed_q    <= 1'b1;
      end_q      <= 1'b0;
      base_q     <= '0;
      offset_q   <= '0;
      wcount_q   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_wen   <= 1'b0;
      inc_addr   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      inc_addr <= 1'b0;
      // A new slot base wins over the consume pulse if both land together.
      if (slot_wen) begin
        armed_q <= 1'b1;
      end else if (inc_addr) begin
        armed_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (accept) begin
            base_q     <= slot_base;
            offset_q   <= DataStartW;
            wcount_q   <= CntW'(1);
            overflow   <= 1'b0;
            end_q      <= pkt_end;
            sram_wen   <= 1'b1;
            sram_addr  <= slot_base + DataStartW;
            sram_wdata <= pkt_data;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          if (sram_ack) begin
            offset_q <= offset_q + ADDR_W'(4);
            if (end_q) begin
`ifdef RESULT_WRITER_LEN_HDR_EN
              sram_wen   <= 1'b1;
              sram_addr  <= base_q;
              sram_wdata <= hdr_word(overflow, wcount_q);
              state_q    <= StHdr;
`else
              sram_wen <= 1'b0;
              inc_addr <= 1'b1;
              state_q  <= StDone;
`endif
            end else begin
              sram_wen <= 1'b0;
              state_q  <= (wcount_q == CapW) ? StDrop : StAccept;
            end
          end
        end
        StAccept: begin
          if (accept) begin
            end_q      <= pkt_end;
            wcount_q   <= wcount_q + CntW'(1);
            sram_wen   <= 1'b1;
            sram_addr  <= base_q + offset_q;
            sram_wdata <= pkt_data;
            state_q    <= StWrite;
          end
        end
        StDrop: begin
          if (accept) begin
            overflow <= 1'b1;
            if (pkt_end) begin
`ifdef RESULT_WRITER_LEN_HDR_EN
              sram_wen   <= 1'b1;
              sram_addr  <= base_q;
              sram_wdata <= hdr_word(1'b1, wcount_q);
              state_q    <= StHdr;
`else
              inc_addr <= 1'b1;
              state_q  <= StDone;
`endif
            end
          end
        end
`ifdef RESULT_WRITER_LEN_HDR_EN
        StHdr: begin
          if (sram_ack) begin
            sram_wen <= 1'b0;
            inc_addr <= 1'b1;
            state_q  <= StDone;
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_packet_writer.sv
// Bench for result_packet_writer: SRAM responder with variable ack delay, packet driver and a
// slot-level reference model of the expected SRAM write list.
module tb_result_packet_writer;

  localparam int unsigned SLOT = 1550;
`ifdef RESULT_WRITER_LEN_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int unsigned CAP   = HDR ? (SLOT - 4) / 4 : SLOT / 4;
  localparam int unsigned START = HDR ? 4 : 0;

  typedef logic [31:0] word_q_t[$];

  logic        tb_clk = 1'b0;
  logic        rst;
  logic [15:0] slot_base;
  logic        slot_wen;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_end;
  logic        pkt_ready;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_wen;
  logic        sram_ack;
  logic        inc_addr;
  logic        overflow;

  result_packet_writer dut (
    .clk        (tb_clk),
    .rst        (rst),
    .slot_base  (slot_base),
    .slot_wen   (slot_wen),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_end    (pkt_end),
    .pkt_ready  (pkt_ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wen   (sram_wen),
    .sram_ack   (sram_ack),
    .inc_addr   (inc_addr),
    .overflow   (overflow)
  );

  always #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad   = 0;

  // Responder / monitor state
  int          cyc = 0;
  int          ack_delay = 2;
  bit          ack_rand = 1'b0;
  int          cur_delay = 1;
  int          wen_cnt = 0;
  logic [15:0] hold_addr;
  logic [31:0] hold_data;
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          inc_cnt = 0;
  int          inc_run = 0;
  int          inc_max_run = 0;
  int          stable_bad = 0;
  int          lat_bad = 0;
  int          last_ack_cyc = -10;
  int          last_acc_cyc = -10;
  int          last_hold = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // SRAM responder and inc_addr monitor, evaluated mid-cycle.
  initial begin
    sram_ack = 1'b0;
    forever begin
      @(negedge tb_clk);
      cyc++;
      if (inc_addr === 1'b1) begin
        inc_cnt++;
        inc_run++;
        if (inc_run > inc_max_run) inc_max_run = inc_run;
        if (inc_run == 1 &&
            cyc != ((last_ack_cyc > last_acc_cyc) ? last_ack_cyc : last_acc_cyc) + 1) lat_bad++;
      end else begin
        inc_run = 0;
      end
      if (sram_ack) begin
        sram_ack = 1'b0;
        wen_cnt  = 0;
      end
      if (sram_wen === 1'b1 && rst === 1'b0) begin
        wen_cnt++;
        if (wen_cnt == 1) begin
          wr_addr.push_back(sram_addr);
          wr_data.push_back(sram_wdata);
          hold_addr = sram_addr;
          hold_data = sram_wdata;
          cur_delay = ack_rand ? int'($urandom_range(1, 4)) : ack_delay;
        end else if (sram_addr !== hold_addr || sram_wdata !== hold_data) begin
          stable_bad++;
        end
        if (wen_cnt >= cur_delay) begin
          sram_ack     = 1'b1;
          last_ack_cyc = cyc;
          last_hold    = wen_cnt;
        end
      end else begin
        wen_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic last, input string tag);
    bit ok;
    ok        = 1'b0;
    pkt_data  = d;
    pkt_valid = 1'b1;
    pkt_end   = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (pkt_ready === 1'b1) begin
        @(posedge tb_clk);
        last_acc_cyc = cyc;
        ok = 1'b1;
      end
      @(negedge tb_clk);
    end
    pkt_valid = 1'b0;
    pkt_end   = 1'b0;
    if (!ok) check({tag, ":accept_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic run_words(input logic [15:0] base, input word_q_t words, input bit do_wen,
                           input bit mid_wen, input string tag);
    logic [15:0] ea[$];
    logic [31:0] ed[$];
    int          inc0;
    int          n;
    int          kept;
    n = words.size();
    slot_base = base;
    if (do_wen) begin
      slot_wen = 1'b1;
      @(negedge tb_clk);
      slot_wen = 1'b0;
    end
    wr_addr.delete();
    wr_data.delete();
    inc0        = inc_cnt;
    inc_max_run = 0;
    stable_bad  = 0;
    lat_bad     = 0;
    for (int i = 0; i < n; i++) begin
      send_word(words[i], (i == n - 1), tag);
      if (i == 0) begin
        check({tag, ":ovf_clr"}, 64'(overflow), 64'd0);
        check({tag, ":wen_n1"}, 64'(sram_wen), 64'd1);
        if (mid_wen) begin
          slot_base = ~base;
          slot_wen  = 1'b1;
          @(negedge tb_clk);
          slot_wen  = 1'b0;
        end
      end
    end
    for (int t = 0; t < 100 && inc_cnt == inc0; t++) @(negedge tb_clk);
    repeat (3) @(negedge tb_clk);

    // Model: first min(n, CAP) words land at consecutive word addresses from the data start.
    kept = (n < int'(CAP)) ? n : int'(CAP);
    for (int i = 0; i < kept; i++) begin
      ea.push_back(16'(int'(base) + int'(START) + 4 * i));
      ed.push_back(words[i]);
    end
    if (HDR) begin
      ea.push_back(base);
      ed.push_back({(n > int'(CAP)), 15'd0, 16'(kept * 4)});
    end
    check({tag, ":nwrites"}, 64'(wr_addr.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s:addr[%0d]", tag, i), 64'(wr_addr[i]), 64'(ea[i]));
      check($sformatf("%s:data[%0d]", tag, i), 64'(wr_data[i]), 64'(ed[i]));
    end
    check({tag, ":inc_pulses"}, 64'(inc_cnt - inc0), 64'd1);
    check({tag, ":inc_width"}, 64'(inc_max_run), 64'd1);
    check({tag, ":inc_latency"}, 64'(lat_bad), 64'd0);
    check({tag, ":stable"}, 64'(stable_bad), 64'd0);
    check({tag, ":overflow"}, 64'(overflow), 64'(n > int'(CAP)));
    check({tag, ":disarmed"}, 64'(pkt_ready), 64'd0);
  endtask

  task automatic run_rand(input logic [15:0] base, input int n, input bit do_wen,
                          input bit mid_wen, input string tag);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    run_words(base, w, do_wen, mid_wen, tag);
  endtask

  initial begin
    word_q_t     w;
    int          inc0;
    rst       = 1'b1;
    slot_base = 16'h0000;
    slot_wen  = 1'b0;
    pkt_data  = '0;
    pkt_valid = 1'b0;
    pkt_end   = 1'b0;
    repeat (3) @(negedge tb_clk);
    check("rst:ready", 64'(pkt_ready), 64'd1);
    check("rst:wen", 64'(sram_wen), 64'd0);
    check("rst:inc", 64'(inc_addr), 64'd0);
    check("rst:ovf", 64'(overflow), 64'd0);
    check("rst:addr", 64'(sram_addr), 64'd0);
    rst = 1'b0;
    @(negedge tb_clk);

    // 1: armed out of reset, 3-word packet
    ack_delay = 2;
    w = '{32'hA0, 32'hA1, 32'hA2};
    run_words(16'h1838, w, 1'b0, 1'b0, "t1");

    // 2: disarmed writer ignores pkt_valid until slot_wen
    wr_addr.delete();
    pkt_data  = 32'h1234_5678;
    pkt_end   = 1'b1;
    pkt_valid = 1'b1;
    repeat (5) begin
      @(negedge tb_clk);
      check("t2:blocked_ready", 64'(pkt_ready), 64'd0);
    end
    check("t2:blocked_writes", 64'(wr_addr.size()), 64'd0);
    pkt_valid = 1'b0;
    pkt_end   = 1'b0;
    run_rand(16'h0000, 3, 1'b1, 1'b0, "t2");

    // 3: single word, slow ack
    ack_delay = 5;
    w = '{32'hDEAD_BEEF};
    run_words(16'h2000, w, 1'b1, 1'b0, "t3");
    check("t3:hold_len", 64'(last_hold), 64'd5);

    // 4: oversize packet, then exact-capacity and capacity+1 edges
    ack_rand = 1'b1;
    run_rand(16'h060E, 400, 1'b1, 1'b0, "t4");
    run_rand(16'($urandom), int'(CAP), 1'b1, 1'b0, "cap_exact");
    run_rand(16'($urandom), int'(CAP) + 1, 1'b1, 1'b0, "cap_plus1");

    // 5: address wrap
    run_rand(16'hFFF8, 4, 1'b1, 1'b0, "t5");

    // slot_wen mid-packet must not move the current slot
    run_rand(16'h5550, 5, 1'b1, 1'b1, "mid_wen");

    // random packets
    for (int k = 0; k < 8; k++) begin
      run_rand(16'($urandom), int'($urandom_range(1, 10)), 1'b1, 1'b0, $sformatf("rnd%0d", k));
    end

    // 6: reset during the write of word 2
    ack_rand  = 1'b0;
    ack_delay = 2;
    slot_base = 16'h3000;
    slot_wen  = 1'b1;
    @(negedge tb_clk);
    slot_wen = 1'b0;
    send_word(32'h1111_1111, 1'b0, "t6");
    ack_delay = 20;
    send_word(32'h2222_2222, 1'b0, "t6");
    check("t6:pre_wen", 64'(sram_wen), 64'd1);
    inc0 = inc_cnt;
    #1 rst = 1'b1;
    #1;
    check("t6:wen", 64'(sram_wen), 64'd0);
    check("t6:ready", 64'(pkt_ready), 64'd1);
    check("t6:inc", 64'(inc_addr), 64'd0);
    @(negedge tb_clk);
    rst = 1'b0;
    repeat (5) @(negedge tb_clk);
    check("t6:no_inc", 64'(inc_cnt - inc0), 64'd0);
    check("t6:ready_after", 64'(pkt_ready), 64'd1);
    ack_delay = 1;
    run_rand(16'h4444, 5, 1'b0, 1'b0, "t6_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
